rcc_vdd_wr_bridge: RTL

//  Core-domain writer for the RCC VDD-domain register block. Turns a single-cycle register write
//  (C1 RSR.RMVF, C2 RSR.RMVF, CSR.LSION) into the level-based raw_*_wren / rcc_vdd_wdata drive
//  the VDD block expects. Closes the loop by synchronising the VDD readback (cur_*) until it

---
 rtl/rcc_vdd_wr_if.sv | 27 ++
 rtl/rcc_vdd_wr_bridge.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/rcc_vdd_wr_if.sv
// rcc_vdd_wr_if: request/status handshake between the RCC register decode and the VDD write bridge.
//   wr_req   decode -> bridge  one-cycle write request
//   wr_sel   decode -> bridge  target select (0:C1 RMVF, 1:C2 RMVF, 2:CSR LSION, 3:reserved)
//   wr_data  decode -> bridge  value to write
//   busy     bridge -> decode  transfer in progress
//   wr_done  bridge -> decode  one-cycle completion pulse
//   wr_rej   bridge -> decode  one-cycle pulse, request dropped
//   wr_err   bridge -> decode  one-cycle pulse with wr_done when the transfer timed out
interface rcc_vdd_wr_if;
    logic       wr_req;
    logic [1:0] wr_sel;
    logic       wr_data;
    logic       busy;
    logic       wr_done;
    logic       wr_rej;
    logic       wr_err;

    modport master (
        output wr_req, wr_sel, wr_data,
        input  busy, wr_done, wr_rej, wr_err
    );

    modport slave (
        input  wr_req, wr_sel, wr_data,
        output busy, wr_done, wr_rej, wr_err
    );
endinterface

// File: rtl/rcc_vdd_wr_bridge.sv
// rcc_vdd_wr_bridge: core-domain writer for the RCC VDD-domain register block.
// Converts a single-cycle register write into the level-based wren/wdata drive of the VDD
// block and closes the loop on the synchronised VDD readback.
// Ports:
//   clk, rst                    core clock, asynchronous active-high reset
//   bus (rcc_vdd_wr_if.slave)   wr_req/wr_sel/wr_data in; busy/wr_done/wr_rej/wr_err out
//   cur_rcc_*                   VDD readback, asynchronous to clk
//   rcc_vdd_wdata               write data to the VDD domain
//   raw_rcc_*_wren              one-hot level write enables
// Build option: define RCC_VDD_WR_TIMEOUT_EN to bound the WAIT state by TIMEOUT_CYC cycles
// (TIMEOUT_CYC must exceed SYNC_STAGES); otherwise wr_err is tied 0.
module rcc_vdd_wr_bridge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned SETUP_CYC   = 2,
    parameter int unsigned HOLD_CYC    = 2,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic         clk,
    input  logic         rst,
    rcc_vdd_wr_if.slave  bus,
    input  logic         cur_rcc_c1_rsr_rmvf,
    input  logic         cur_rcc_c2_rsr_rmvf,
    input  logic         cur_rcc_csr_lsion,
    output logic         rcc_vdd_wdata,
    output logic         raw_rcc_c1_rsr_rmvf_wren,
    output logic         raw_rcc_c2_rsr_rmvf_wren,
    output logic         raw_rcc_csr_lsion_wren
);

    localparam int unsigned MAX_A   = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
    localparam int unsigned MAX_B   = (MAX_A > TIMEOUT_CYC) ? MAX_A : TIMEOUT_CYC;
    localparam int unsigned CNT_MAX = (MAX_B > SYNC_STAGES) ? MAX_B : SYNC_STAGES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;

`ifdef RCC_VDD_WR_TIMEOUT_EN
    // WAIT counts down the whole timeout; the ack window opens SYNC_STAGES cycles after entry.
    localparam int unsigned CNT_WAIT = TIMEOUT_CYC - 1;
    localparam int unsigned ACK_OPEN = TIMEOUT_CYC - 1 - SYNC_STAGES;
`else
    // WAIT counts down only the stale-readback mask.
    localparam int unsigned CNT_WAIT = SYNC_STAGES;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [1:0]             sel_q;
    logic                   data_q;
    logic [SYNC_STAGES-1:0] sync_c1;
    logic [SYNC_STAGES-1:0] sync_c2;
    logic [SYNC_STAGES-1:0] sync_lsion;
`ifdef RCC_VDD_WR_TIMEOUT_EN
    logic                   timed_out;
`endif

    logic             synced_sel_c;
    logic             cnt_zero_c;
    logic [CNT_W-1:0] cnt_dec_c;
    logic             ack_open_c;
    logic             ack_c;
    logic             accept_c;

    // Readback of the currently selected target, after synchronisation.
    always_comb begin
        synced_sel_c = sync_lsion[SYNC_STAGES-1];
        case (sel_q)
            2'd0:    synced_sel_c = sync_c1[SYNC_STAGES-1];
            2'd1:    synced_sel_c = sync_c2[SYNC_STAGES-1];
            default: synced_sel_c = sync_lsion[SYNC_STAGES-1];
        endcase
    end

    // Saturating down-counter step.
    assign cnt_zero_c = (cnt == '0);
    assign cnt_dec_c  = cnt_zero_c ? '0 : cnt - CNT_W'(1);

`ifdef RCC_VDD_WR_TIMEOUT_EN
    assign ack_open_c = (cnt <= CNT_W'(ACK_OPEN));
`else
    assign ack_open_c = cnt_zero_c;
`endif

    assign ack_c    = ack_open_c && (synced_sel_c == data_q);
    // The wr_done cycle still counts as busy for new requests.
    assign accept_c = bus.wr_req && (state == IDLE) && !bus.wr_done && (bus.wr_sel != 2'd3);

    // Readback synchronisers, FSM, counter and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                    <= IDLE;
            cnt                      <= '0;
            sel_q                    <= 2'd0;
            data_q                   <= 1'b0;
            sync_c1                  <= '0;
            sync_c2                  <= '0;
            sync_lsion               <= '0;
            rcc_vdd_wdata            <= 1'b0;
            raw_rcc_c1_rsr_rmvf_wren <= 1'b0;
            raw_rcc_c2_rsr_rmvf_wren <= 1'b0;
            raw_rcc_csr_lsion_wren   <= 1'b0;
            bus.busy                 <= 1'b0;
            bus.wr_done              <= 1'b0;
            bus.wr_rej               <= 1'b0;
`ifdef RCC_VDD_WR_TIMEOUT_EN
            bus.wr_err               <= 1'b0;
            timed_out                <= 1'b0;
`endif
        end else begin
            sync_c1    <= {sync_c1[SYNC_STAGES-2:0], cur_rcc_c1_rsr_rmvf};
            sync_c2    <= {sync_c2[SYNC_STAGES-2:0], cur_rcc_c2_rsr_rmvf};
            sync_lsion <= {sync_lsion[SYNC_STAGES-2:0], cur_rcc_csr_lsion};

            bus.wr_done <= 1'b0;
            bus.wr_rej  <= bus.wr_req && !accept_c;
`ifdef RCC_VDD_WR_TIMEOUT_EN
            bus.wr_err  <= 1'b0;
`endif

            case (state)
                IDLE: begin
                    if (accept_c) begin
                        sel_q         <= bus.wr_sel;
                        data_q        <= bus.wr_data;
                        rcc_vdd_wdata <= bus.wr_data;
                        bus.busy      <= 1'b1;
                        cnt           <= CNT_W'(SETUP_CYC - 1);
                        state         <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt_zero_c) begin
                        raw_rcc_c1_rsr_rmvf_wren <= (sel_q == 2'd0);
                        raw_rcc_c2_rsr_rmvf_wren <= (sel_q == 2'd1);
                        raw_rcc_csr_lsion_wren   <= (sel_q == 2'd2);
                        cnt                      <= CNT_W'(CNT_WAIT);
                        state                    <= WAIT;
                    end else begin
                        cnt <= cnt_dec_c;
                    end
                end
                WAIT: begin
                    // Ack is tested first so it wins over a same-cycle expiry.
                    if (ack_c) begin
                        raw_rcc_c1_rsr_rmvf_wren <= 1'b0;
                        raw_rcc_c2_rsr_rmvf_wren <= 1'b0;
                        raw_rcc_csr_lsion_wren   <= 1'b0;
                        cnt                      <= CNT_W'(HOLD_CYC - 1);
                        state                    <= HOLD;
`ifdef RCC_VDD_WR_TIMEOUT_EN
                        timed_out                <= 1'b0;
                    end else if (cnt_zero_c) begin
                        raw_rcc_c1_rsr_rmvf_wren <= 1'b0;
                        raw_rcc_c2_rsr_rmvf_wren <= 1'b0;
                        raw_rcc_csr_lsion_wren   <= 1'b0;
                        cnt                      <= CNT_W'(HOLD_CYC - 1);
                        state                    <= HOLD;
                        timed_out                <= 1'b1;
`endif
                    end else begin
                        cnt <= cnt_dec_c;
                    end
                end
                HOLD: begin
                    if (cnt_zero_c) begin
                        rcc_vdd_wdata <= 1'b0;
                        bus.busy      <= 1'b0;
                        bus.wr_done   <= 1'b1;
`ifdef RCC_VDD_WR_TIMEOUT_EN
                        bus.wr_err    <= timed_out;
                        timed_out     <= 1'b0;
`endif
                        state         <= IDLE;
                    end else begin
                        cnt <= cnt_dec_c;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef RCC_VDD_WR_TIMEOUT_EN
    assign bus.wr_err = 1'b0;
`endif

endmodule
